// File: rtl/cva5_config.sv
// cva5_config
//   Shared configuration constants for the CVA5 core slice.
//   Holds the writeback scheduler limits alongside the id width used by
//   cva5_types.
//   Ports: none (package).
package cva5_config;

  // Upper bound on the number of writeback requesters a scheduler may serve.
  localparam int MAX_NUM_UNITS = 8;

  // Default number of denials before a pending writeback unit is starved.
  localparam int WB_MAX_WAIT_DEFAULT = 7;

  // log2 of the number of in-flight instruction ids.
  localparam int LOG2_MAX_IDS = 3;

endpackage

// File: rtl/cva5_types.sv
// cva5_types
//   Shared type definitions for the CVA5 core slice.
//   Ports: none (package).
//     id_t        - in-flight instruction id
//     wb_packet_t - {valid, id, data} writeback packet to the register file
package cva5_types;
  import cva5_config::*;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;

  typedef struct packed {
    logic        valid;
    id_t         id;
    logic [31:0] data;
  } wb_packet_t;

endpackage

// File: rtl/priority_encoder.sv
// priority_encoder
//   Encodes the index of the lowest set bit of i_vector.
//   Output is 0 when i_vector is all zeros; callers qualify with |i_vector.
//   Ports:
//     i_vector  [WIDTH]          - request vector
//     o_encoded [clog2(WIDTH)]   - index of the lowest set bit (1 bit wide when WIDTH==1)
module priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]                              i_vector,
  output logic [((WIDTH == 1) ? 1 : $clog2(WIDTH))-1:0] o_encoded
);

  localparam int OUT_W = (WIDTH == 1) ? 1 : $clog2(WIDTH);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_encoded = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o_encoded = i_vector[i] ? OUT_W'(i) : o_encoded;
    end
  end

endmodule

// File: rtl/writeback_rr_select.sv
// writeback_rr_select
//   Round-robin one-hot selector: grants the first requesting index at or
//   above i_ptr, wrapping past the top index back to 0.
//   Ports:
//     i_request [NUM_UNITS] - request vector (starved units)
//     i_ptr     [PTR_W]     - round-robin start index
//     o_grant   [NUM_UNITS] - one-hot grant, zero when i_request is zero
module writeback_rr_select #(
  parameter int NUM_UNITS = 5,
  parameter int PTR_W     = 3
) (
  input  logic [NUM_UNITS-1:0] i_request,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_UNITS-1:0] o_grant
);

  logic [NUM_UNITS-1:0] w_upper_mask;
  logic [NUM_UNITS-1:0] w_upper_req;
  logic [NUM_UNITS-1:0] w_src;

  // Mask of indices at or above the pointer.
  always_comb begin
    w_upper_mask = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_upper_mask[i] = (i >= int'(i_ptr));
    end
  end

  assign w_upper_req = i_request & w_upper_mask;

  // No request at/above the pointer means the search wraps to index 0,
  // which is simply the lowest request in the unmasked vector.
  assign w_src = (|w_upper_req) ? w_upper_req : i_request;

  // Isolate the lowest set bit (two's-complement trick).
  assign o_grant = w_src & (~w_src + NUM_UNITS'(1'b1));

endmodule

// File: rtl/writeback_scheduler.sv
// writeback_scheduler
//   Arbitrates NUM_WB_UNITS writeback requesters onto one writeback port.
//   Normal grants are fixed priority (lowest index). A unit denied MAX_WAIT
//   times becomes starved; starved units preempt and are served round-robin.
//   Ports:
//     clk          - sole clock
//     rst          - synchronous active-high reset
//     unit_done    [N]      - per-unit result pending, held until acked
//     unit_id      [N] id_t - per-unit instruction id
//     unit_rd      [N] x 32 - per-unit result data
//     unit_ack     [N]      - combinational one-hot-or-zero grant
//     wb_packet    wb_packet_t - registered {valid, id, data}, one cycle after ack
//     starve_grant - registered; high with wb_packet.valid for a starved grant
module writeback_scheduler
  import cva5_config::*;
  import cva5_types::*;
#(
  parameter int NUM_WB_UNITS = 5,
  parameter int MAX_WAIT     = WB_MAX_WAIT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WB_UNITS-1:0] unit_done,
  input  id_t                     unit_id [NUM_WB_UNITS],
  input  logic [31:0]             unit_rd [NUM_WB_UNITS],
  output logic [NUM_WB_UNITS-1:0] unit_ack,
  output wb_packet_t              wb_packet,
  output logic                    starve_grant
);

  localparam int PTR_W  = (NUM_WB_UNITS == 1) ? 1 : $clog2(NUM_WB_UNITS);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0]       r_wait [NUM_WB_UNITS];
  logic [PTR_W-1:0]        r_rr_ptr;
  wb_packet_t              r_wb_packet;
  logic                    r_starve_grant;

  logic [NUM_WB_UNITS-1:0] w_starved;
  logic                    w_any_starved;
  logic [NUM_WB_UNITS-1:0] w_rr_grant;
  logic [NUM_WB_UNITS-1:0] w_fp_grant;
  logic [PTR_W-1:0]        w_fp_idx;
  logic [NUM_WB_UNITS-1:0] w_grant;
  logic [PTR_W-1:0]        w_grant_idx;
  logic                    w_granted;
  logic [PTR_W-1:0]        w_rr_ptr_next;

  // A unit is starved once it is pending and its wait counter has saturated.
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_WB_UNITS; i++) begin
      w_starved[i] = unit_done[i] && (r_wait[i] == WAIT_W'(MAX_WAIT));
    end
  end

  assign w_any_starved = |w_starved;

  priority_encoder #(
    .WIDTH (NUM_WB_UNITS)
  ) u_fp_encoder (
    .i_vector  (unit_done),
    .o_encoded (w_fp_idx)
  );

  writeback_rr_select #(
    .NUM_UNITS (NUM_WB_UNITS),
    .PTR_W     (PTR_W)
  ) u_rr_select (
    .i_request (w_starved),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_rr_grant)
  );

  // Fixed-priority one-hot from the encoded lowest pending index.
  always_comb begin
    w_fp_grant = '0;
    if (|unit_done) begin
      w_fp_grant = NUM_WB_UNITS'(1'b1) << w_fp_idx;
    end else begin
      w_fp_grant = '0;
    end
  end

  // Final grant: reset suppresses everything, starved units preempt.
  always_comb begin
    w_grant = '0;
    if (rst) begin
      w_grant = '0;
    end else if (w_any_starved) begin
      w_grant = w_rr_grant;
    end else begin
      w_grant = w_fp_grant;
    end
  end

  assign unit_ack  = w_grant;
  assign w_granted = |w_grant;

  // Recover the granted index for the payload mux and pointer update.
  priority_encoder #(
    .WIDTH (NUM_WB_UNITS)
  ) u_grant_encoder (
    .i_vector  (w_grant),
    .o_encoded (w_grant_idx)
  );

  assign w_rr_ptr_next = (w_grant_idx == PTR_W'(NUM_WB_UNITS - 1)) ? '0
                                                                   : w_grant_idx + PTR_W'(1'b1);

  // Wait counters, round-robin pointer and the registered writeback packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WB_UNITS; i++) begin
        r_wait[i] <= '0;
      end
      r_rr_ptr       <= '0;
      r_wb_packet    <= '0;
      r_starve_grant <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WB_UNITS; i++) begin
        if (!unit_done[i] || w_grant[i]) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != WAIT_W'(MAX_WAIT)) begin
          r_wait[i] <= r_wait[i] + WAIT_W'(1'b1);
        end else begin
          r_wait[i] <= r_wait[i];
        end
      end

      // The pointer only moves past a unit that won through starvation.
      if (w_granted && w_any_starved) begin
        r_rr_ptr <= w_rr_ptr_next;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end

      r_wb_packet.valid <= w_granted;
      // id/data keep their last value on idle cycles.
      if (w_granted) begin
        r_wb_packet.id   <= unit_id[w_grant_idx];
        r_wb_packet.data <= unit_rd[w_grant_idx];
      end else begin
        r_wb_packet.id   <= r_wb_packet.id;
        r_wb_packet.data <= r_wb_packet.data;
      end

      r_starve_grant <= w_granted && w_any_starved;
    end
  end

  assign wb_packet    = r_wb_packet;
  assign starve_grant = r_starve_grant;

endmodule

// File: tb/tb_writeback_scheduler.sv
// tb_writeback_scheduler
//   Directed scoreboard bench: a 5-unit scheduler and a 1-unit scheduler.
//   Stimulus checks the combinational ack against hand-computed values and
//   queues the expected packet; monitors pop and compare registered packets.
module tb_writeback_scheduler;
  import cva5_types::*;

  localparam int N = 5;

  typedef struct packed {
    id_t         id;
    logic [31:0] data;
    logic        st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] unit_done;
  logic [N-1:0] unit_ack;
  id_t          unit_id [N];
  logic [31:0]  unit_rd [N];
  wb_packet_t   wb_packet;
  logic         starve_grant;

  logic [0:0]   done1;
  logic [0:0]   ack1;
  id_t          id1 [1];
  logic [31:0]  rd1 [1];
  wb_packet_t   pkt1;
  logic         st1;

  exp_t q5[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  writeback_scheduler #(.NUM_WB_UNITS(N), .MAX_WAIT(7)) dut (
    .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id),
    .unit_rd(unit_rd), .unit_ack(unit_ack), .wb_packet(wb_packet),
    .starve_grant(starve_grant)
  );

  writeback_scheduler #(.NUM_WB_UNITS(1), .MAX_WAIT(7)) dut1 (
    .clk(clk), .rst(rst), .unit_done(done1), .unit_id(id1),
    .unit_rd(rd1), .unit_ack(ack1), .wb_packet(pkt1),
    .starve_grant(st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One 5-unit cycle: drive done, check ack at negedge, queue the packet.
  task automatic step(input logic [N-1:0] done, input logic [N-1:0] exp_ack,
                      input logic exp_st, input string tag);
    unit_done = done;
    @(negedge clk);
    check({tag, " ack"}, 64'(unit_ack), 64'(exp_ack));
    for (int k = 0; k < N; k++) begin
      if (exp_ack[k]) q5.push_back(exp_t'{unit_id[k], unit_rd[k], exp_st});
    end
    @(posedge clk);
    #1;
  endtask

  // One 1-unit cycle.
  task automatic step1(input logic done, input logic exp_ack, input string tag);
    done1 = done;
    @(negedge clk);
    check({tag, " ack1"}, 64'(ack1), 64'(exp_ack));
    if (exp_ack) q1.push_back(exp_t'{id1[0], rd1[0], 1'b0});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the 5-unit instance.
  always @(negedge clk) begin
    exp_t e;
    if (wb_packet.valid === 1'b1) begin
      if (q5.size() == 0) begin
        check("pkt5 unexpected", 64'({wb_packet.id, wb_packet.data}), 64'(0));
      end else begin
        e = q5.pop_front();
        check("pkt5", 64'({wb_packet.id, wb_packet.data, starve_grant}),
              64'({e.id, e.data, e.st}));
      end
    end else begin
      check("starve5 idle", 64'(starve_grant), 64'(0));
    end
  end

  // Scoreboard monitor for the 1-unit instance.
  always @(negedge clk) begin
    exp_t e;
    if (pkt1.valid === 1'b1) begin
      if (q1.size() == 0) begin
        check("pkt1 unexpected", 64'({pkt1.id, pkt1.data}), 64'(0));
      end else begin
        e = q1.pop_front();
        check("pkt1", 64'({pkt1.id, pkt1.data, st1}), 64'({e.id, e.data, e.st}));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    unit_done = '0;
    done1     = 1'b0;
    for (int i = 0; i < N; i++) unit_id[i] = id_t'(i + 1);
    unit_rd[0] = 32'hA000_0000;
    unit_rd[1] = 32'hA111_1111;
    unit_rd[2] = 32'hDEAD_BEEF;
    unit_rd[3] = 32'hA333_3333;
    unit_rd[4] = 32'hA444_4444;
    id1[0]     = 3'd6;
    rd1[0]     = 32'h1234_5678;

    // Reset state and grant suppression while rst is high.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset pkt", 64'(wb_packet), 64'(0));
    check("reset starve", 64'(starve_grant), 64'(0));
    unit_done = '1;
    #1;
    check("ack under rst", 64'(unit_ack), 64'(0));
    unit_done = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, then idle: packet id/data hold with valid low.
    step(5'b00100, 5'b00100, 1'b0, "single");
    step(5'b00000, 5'b00000, 1'b0, "single idle");
    check("idle hold", 64'(wb_packet), 64'({1'b0, 3'd3, 32'hDEAD_BEEF}));

    // Fixed priority until unit 1 starves; rr_ptr moves to 2.
    repeat (7) step(5'b00011, 5'b00001, 1'b0, "fp");
    step(5'b00011, 5'b00010, 1'b1, "fp starve1");
    step(5'b00011, 5'b00001, 1'b0, "fp after");
    step(5'b00000, 5'b00000, 1'b0, "fp idle");

    // Starve unit 3 from rr_ptr=2; rr_ptr moves to 4.
    repeat (7) step(5'b01001, 5'b00001, 1'b0, "ptr4");
    step(5'b01001, 5'b01000, 1'b1, "ptr4 starve3");
    step(5'b00000, 5'b00000, 1'b0, "ptr4 idle");

    // Units 1 and 3 starve together with rr_ptr=4: wrap to 1, then 3.
    repeat (7) step(5'b01011, 5'b00001, 1'b0, "wrap");
    step(5'b01011, 5'b00010, 1'b1, "wrap starve1");
    step(5'b01011, 5'b01000, 1'b1, "wrap starve3");
    step(5'b01011, 5'b00001, 1'b0, "wrap fp");
    step(5'b00000, 5'b00000, 1'b0, "wrap idle");

    // Reset mid-operation with all units pending.
    step(5'b11111, 5'b00001, 1'b0, "pre rst");
    step(5'b11111, 5'b00001, 1'b0, "pre rst");
    rst = 1'b1;
    step(5'b11111, 5'b00000, 1'b0, "mid rst");
    check("mid rst pkt", 64'(wb_packet), 64'(0));
    check("mid rst starve", 64'(starve_grant), 64'(0));
    rst = 1'b0;
    repeat (7) step(5'b11111, 5'b00001, 1'b0, "post rst");
    step(5'b11111, 5'b00010, 1'b1, "post rst s1");
    step(5'b11111, 5'b00100, 1'b1, "post rst s2");
    step(5'b11111, 5'b01000, 1'b1, "post rst s3");
    step(5'b11111, 5'b10000, 1'b1, "post rst s4");
    step(5'b11111, 5'b00001, 1'b0, "post rst fp");
    step(5'b00000, 5'b00000, 1'b0, "post rst idle");

    // Single-unit instance: every pending cycle is acked, never starved.
    repeat (3) step1(1'b1, 1'b1, "n1 burst");
    step1(1'b0, 1'b0, "n1 idle");
    repeat (9) step1(1'b1, 1'b1, "n1 long");
    step1(1'b0, 1'b0, "n1 drain");
    step1(1'b0, 1'b0, "n1 drain");

    @(negedge clk);
    check("q5 drained", 64'(q5.size()), 64'(0));
    check("q1 drained", 64'(q1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
